// File: rtl/test_gen_pkg.sv
// Shared types and constants for the arithmetic stimulus/response test generators.
// Holds the FSM encoding, LFSR geometry and the LFSR step function.
package test_gen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      PASS,
      FAIL
   } state_t;

   localparam int             LFSR_W    = 16;
   localparam logic [15:0]    LFSR_TAPS = 16'hB400;
   localparam int             OPND_W    = 8;

   typedef logic [OPND_W-1:0] opnd_t;
   typedef logic [LFSR_W-1:0] lfsr_t;

   // Fibonacci step: shift left, parity of taps 15/13/12/10 enters at bit 0.
   function automatic lfsr_t lfsr_step(input lfsr_t l);
      return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/test_gen_add_i8_if.sv
// Operand/result bus between the test generator (master) and the adder under test (slave).
// Operands are qualified by dut_en; the result has a fixed latency and no handshake.
interface test_gen_add_i8_if;
   import test_gen_pkg::*;

   opnd_t dut_a;
   opnd_t dut_b;
   logic  dut_en;
   opnd_t dut_y;

   modport master (output dut_a, output dut_b, output dut_en, input dut_y);
   modport slave  (input dut_a, input dut_b, input dut_en, output dut_y);

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, loads seed on reset and advances one step per enabled cycle.
// Output is the current register state; no backpressure, en simply stalls the sequence.
module lfsr16
   import test_gen_pkg::*;
(
   input  logic  clock,
   input  logic  reset_n,
   input  logic  en,
   input  lfsr_t seed,
   output lfsr_t q
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= seed;
      end else if (en) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/test_gen_add_i8.sv
// Stimulus/response engine for an 8-bit adder: LFSR operands out, delay-matched golden check in.
// Results are checked LATENCY cycles after issue; fail/finish are sticky until reset.
module test_gen_add_i8
   import test_gen_pkg::*;
#(
   parameter int          NUM_VECTORS = 256,
   parameter int          LATENCY     = 2,
   parameter int          START_DELAY = 4,
   parameter logic [15:0] SEED        = 16'h0001
) (
   input  logic                      clock,
   input  logic                      reset_n,
   test_gen_add_i8_if.master         dut_bus,
   output logic                      fail,
   output logic                      finish,
   output logic [15:0]               checked
);

   localparam logic [15:0] NUM_VEC_C   = 16'(NUM_VECTORS);
   localparam logic [7:0]  START_DLY_C = 8'(START_DELAY);

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        dly_cnt;
   logic [15:0]       iss_cnt;
   lfsr_t             lfsr_q;
   logic              issue;
   logic              chk_vld;
   logic              mismatch;
   logic              upstream_busy;
   logic [LATENCY:1]  pipe_vld;
   opnd_t             pipe_exp [1:LATENCY];

   lfsr16 u_lfsr (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (issue),
      .seed    (SEED),
      .q       (lfsr_q)
   );

   assign chk_vld  = pipe_vld[LATENCY];
   assign mismatch = chk_vld && (dut_bus.dut_y != pipe_exp[LATENCY]);

   // Anything still in flight ahead of the stage being compared this cycle.
   always_comb begin
      upstream_busy = 1'b0;
      for (int i = 1; i < LATENCY; i++) begin
         upstream_busy = upstream_busy | pipe_vld[i];
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (dly_cnt == START_DLY_C) begin
               issue     = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (mismatch) begin
               state_nxt = FAIL;
            end else if (iss_cnt == NUM_VEC_C) begin
               state_nxt = DRAIN;
            end else begin
               issue = 1'b1;
            end
         end
         DRAIN: begin
            if (mismatch) begin
               state_nxt = FAIL;
            end else if (!upstream_busy) begin
               state_nxt = PASS;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         dly_cnt        <= 8'd0;
         iss_cnt        <= 16'd0;
         dut_bus.dut_a  <= '0;
         dut_bus.dut_b  <= '0;
         dut_bus.dut_en <= 1'b0;
         fail           <= 1'b0;
         finish         <= 1'b0;
         checked        <= 16'd0;
         pipe_vld       <= '0;
      end else begin
         state          <= state_nxt;
         dut_bus.dut_en <= issue;
         fail           <= (state_nxt == FAIL);
         finish         <= (state_nxt == FAIL) || (state_nxt == PASS);

         if (state == IDLE && !issue) begin
            dly_cnt <= dly_cnt + 8'd1;
         end

         if (issue) begin
            iss_cnt       <= iss_cnt + 16'd1;
            dut_bus.dut_a <= lfsr_q[7:0];
            dut_bus.dut_b <= lfsr_q[15:8];
         end

         if (chk_vld && (state == RUN || state == DRAIN) && checked != 16'hFFFF) begin
            checked <= checked + 16'd1;
         end

         // Terminal states discard anything still pending so checked freezes.
         if (state_nxt == FAIL || state_nxt == PASS) begin
            pipe_vld <= '0;
         end else begin
            pipe_vld[1] <= dut_bus.dut_en;
            for (int i = 2; i <= LATENCY; i++) begin
               pipe_vld[i] <= pipe_vld[i-1];
            end
         end
      end
   end

   // Expected sums need no reset: they are only observed behind a valid bit.
   always_ff @(posedge clock) begin
      pipe_exp[1] <= dut_bus.dut_a + dut_bus.dut_b;
      for (int i = 2; i <= LATENCY; i++) begin
         pipe_exp[i] <= pipe_exp[i-1];
      end
   end

endmodule

// File: tb/tb_test_gen_add_i8.sv
// Bench for test_gen_add_i8: a main generator driving a 2-stage adder with optional fault,
// plus a single-vector LATENCY=1 generator whose only vector overflows the 8-bit sum.
module tb_test_gen_add_i8;
   import test_gen_pkg::*;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic fault_mode = 1'b0;

   always #5 clock = ~clock;

   test_gen_add_i8_if m_bus ();
   test_gen_add_i8_if s_bus ();

   logic        m_fail, m_finish;
   logic [15:0] m_checked;
   logic        s_fail, s_finish;
   logic [15:0] s_checked;

   test_gen_add_i8 #(
      .NUM_VECTORS (256),
      .LATENCY     (2),
      .START_DELAY (4),
      .SEED        (16'h0001)
   ) u_main (
      .clock   (clock),
      .reset_n (reset_n),
      .dut_bus (m_bus),
      .fail    (m_fail),
      .finish  (m_finish),
      .checked (m_checked)
   );

   test_gen_add_i8 #(
      .NUM_VECTORS (1),
      .LATENCY     (1),
      .START_DELAY (0),
      .SEED        (16'h01FF)
   ) u_small (
      .clock   (clock),
      .reset_n (reset_n),
      .dut_bus (s_bus),
      .fail    (s_fail),
      .finish  (s_finish),
      .checked (s_checked)
   );

   // Adder under test: combinational sum then two registers; fault flips bit 0 high on result 10.
   logic [7:0]  m_y1, m_y2;
   logic        m_v1;
   logic [15:0] m_res;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_y1  <= 8'd0;
         m_y2  <= 8'd0;
         m_v1  <= 1'b0;
         m_res <= 16'd0;
      end else begin
         m_v1 <= m_bus.dut_en;
         m_y1 <= m_bus.dut_a + m_bus.dut_b;
         m_y2 <= (fault_mode && m_v1 && m_res == 16'd9) ? (m_y1 | 8'h01) : m_y1;
         if (m_v1) m_res <= m_res + 16'd1;
      end
   end
   assign m_bus.dut_y = m_y2;

   logic [7:0] s_y;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) s_y <= 8'd0;
      else          s_y <= s_bus.dut_a + s_bus.dut_b;
   end
   assign s_bus.dut_y = s_y;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] log1 [50];
   logic [15:0] log2 [256];
   logic [15:0] lm;
   int          n1, n2, fin_cyc, fail_cyc, vec_bad;
   logic        early_en;

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_en",      32'(m_bus.dut_en), 32'h0);
      chk("rst_a",       32'(m_bus.dut_a),  32'h0);
      chk("rst_b",       32'(m_bus.dut_b),  32'h0);
      chk("rst_fail",    32'(m_fail),       32'h0);
      chk("rst_finish",  32'(m_finish),     32'h0);
      chk("rst_checked", 32'(m_checked),    32'h0);

      // Run 1: first-vector timing, then a reset pulse after 50 vectors.
      reset_n  = 1'b1;
      n1       = 0;
      early_en = 1'b0;
      for (int c = 0; c < 100 && n1 < 50; c++) begin
         @(negedge clock);
         if (c < 4) early_en = early_en | m_bus.dut_en;
         if (m_bus.dut_en) begin
            log1[n1] = {m_bus.dut_b, m_bus.dut_a};
            n1++;
         end
         case (c)
            0: begin
               chk("s_en_c0", 32'(s_bus.dut_en), 32'h1);
               chk("s_a_c0",  32'(s_bus.dut_a),  32'hFF);
               chk("s_b_c0",  32'(s_bus.dut_b),  32'h01);
            end
            1: chk("s_finish_c1", 32'(s_finish), 32'h0);
            2: begin
               chk("s_finish_c2",  32'(s_finish),  32'h1);
               chk("s_ovf_nofail", 32'(s_fail),    32'h0);
               chk("s_checked_c2", 32'(s_checked), 32'h1);
            end
            4: begin
               chk("first_en", 32'(m_bus.dut_en), 32'h1);
               chk("first_a",  32'(m_bus.dut_a),  32'h01);
               chk("first_b",  32'(m_bus.dut_b),  32'h00);
            end
            5: begin
               chk("second_a", 32'(m_bus.dut_a), 32'h02);
               chk("second_b", 32'(m_bus.dut_b), 32'h00);
            end
            6: chk("checked_c6", 32'(m_checked), 32'h0);
            7: chk("checked_c7", 32'(m_checked), 32'h1);
            default: begin
            end
         endcase
      end
      chk("idle_no_en", 32'(early_en), 32'h0);
      chk("run1_vecs",  32'(n1),       32'd50);

      #1 reset_n = 1'b0;
      #1;
      chk("arst_en",      32'(m_bus.dut_en), 32'h0);
      chk("arst_a",       32'(m_bus.dut_a),  32'h0);
      chk("arst_b",       32'(m_bus.dut_b),  32'h0);
      chk("arst_checked", 32'(m_checked),    32'h0);
      chk("arst_s_fin",   32'(s_finish),     32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      // Run 2: full passing run after the mid-run reset.
      n2      = 0;
      fin_cyc = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         if (m_bus.dut_en && n2 < 256) begin
            log2[n2] = {m_bus.dut_b, m_bus.dut_a};
            n2++;
         end
         if (m_finish) begin
            fin_cyc = c;
            break;
         end
      end
      chk("pass_cycle",   32'(fin_cyc),   32'd262);
      chk("pass_fail",    32'(m_fail),    32'h0);
      chk("pass_finish",  32'(m_finish),  32'h1);
      chk("pass_checked", 32'(m_checked), 32'd256);
      chk("pass_issues",  32'(n2),        32'd256);

      vec_bad = 0;
      for (int i = 0; i < 50; i++) if (log2[i] !== log1[i]) vec_bad++;
      chk("restart_match", 32'(vec_bad), 32'h0);

      vec_bad = 0;
      lm      = 16'h0001;
      for (int i = 0; i < 256; i++) begin
         if (log2[i] !== lm) vec_bad++;
         lm = {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
      end
      chk("lfsr_seq", 32'(vec_bad), 32'h0);

      repeat (5) @(negedge clock);
      chk("pass_hold_fin", 32'(m_finish),     32'h1);
      chk("pass_hold_en",  32'(m_bus.dut_en), 32'h0);
      chk("pass_hold_chk", 32'(m_checked),    32'd256);

      // Run 3: corrupted 10th result.
      reset_n    = 1'b0;
      fault_mode = 1'b1;
      @(negedge clock);
      reset_n  = 1'b1;
      fail_cyc = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (m_fail) begin
            fail_cyc = c;
            break;
         end
      end
      chk("fault_cycle",   32'(fail_cyc),     32'd16);
      chk("fault_finish",  32'(m_finish),     32'h1);
      chk("fault_checked", 32'(m_checked),    32'd10);
      chk("fault_en",      32'(m_bus.dut_en), 32'h0);
      repeat (4) @(negedge clock);
      chk("fault_hold_chk",  32'(m_checked),    32'd10);
      chk("fault_hold_en",   32'(m_bus.dut_en), 32'h0);
      chk("fault_hold_fail", 32'(m_fail),       32'h1);
      chk("fault_hold_fin",  32'(m_finish),     32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
